// File: rtl/div_pkg.sv
// Shared constants for the iterative divider family.
// Reused by the signed wrapper that does sign fix-up around divu_iter.
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 6;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/divu_step.sv
// One restoring radix-2 division iteration.
// Shifts the next dividend bit into R, then keeps the trial difference if it did not go negative.
module divu_step #(
    parameter int W = 32
) (
    input  logic [W:0]   r_i,
    input  logic [W-1:0] q_i,
    input  logic [W-1:0] d_i,
    output logic [W:0]   r_next_o,
    output logic [W-1:0] q_next_o
);

    logic [W:0] s;
    logic [W:0] t;
    logic       unused_msb;

    // The partial remainder is always below D, so its top bit never matters.
    assign unused_msb = r_i[W];
    assign s = {r_i[W-1:0], q_i[W-1]};
    assign t = s - {1'b0, d_i};

    // Restore on a negative trial, otherwise accept it and emit a 1.
    always_comb begin
        if (!t[W]) begin
            r_next_o = t;
            q_next_o = {q_i[W-2:0], 1'b1};
        end else begin
            r_next_o = s;
            q_next_o = {q_i[W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/divu_iter.sv
// Iterative unsigned divider (DIVU): one quotient bit per clock.
// Quotient goes to LO, remainder to HI; the core stalls while busy.
module divu_iter
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             dz_q, dz_d;

    logic [WIDTH:0]   rem_nx;
    logic [WIDTH-1:0] quo_nx;

    divu_step #(
        .W(WIDTH)
    ) u_step (
        .r_i     (rem_q),
        .q_i     (quo_q),
        .d_i     (dvs_q),
        .r_next_o(rem_nx),
        .q_next_o(quo_nx)
    );

    // Sequencing: accept in IDLE/DONE, iterate in RUN, publish on the last step.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    dvs_d   = divisor;
                    quo_d   = dividend;
                    rem_d   = '0;
                    cnt_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                rem_d = rem_nx;
                quo_d = quo_nx;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_DONE;
                    q_d     = quo_nx;
                    r_d     = rem_nx[WIDTH-1:0];
                    dz_d    = (dvs_q == '0);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and result registers; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
        end
    end

    assign busy     = (state_q == S_RUN);
    assign done     = (state_q == S_DONE);
    assign q        = q_q;
    assign r        = r_q;
    assign div_zero = dz_q;

endmodule

// File: tb/tb_divu_iter.sv
// Scoreboard bench for divu_iter: driver pushes reference results,
// a negedge monitor pops and compares on every done pulse.
module tb_divu_iter;
    import div_pkg::*;

    localparam int W = DIV_WIDTH;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         busy;
    logic         done;
    logic         div_zero;

    divu_iter dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .dividend(dividend),
        .divisor (divisor),
        .q       (q),
        .r       (r),
        .busy    (busy),
        .done    (done),
        .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int unsigned  acc;
    } exp_t;

    exp_t sb[$];
    int   nvec = 0;
    int   nfail = 0;
    int   busy_run = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] want);
        nvec++;
        if (act !== want) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endtask

    function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b,
                                   int unsigned acc);
        exp_t e;
        e.a   = a;
        e.b   = b;
        e.acc = acc;
        if (b == 0) begin
            e.q  = '1;
            e.r  = a;
            e.dz = 1'b1;
        end else begin
            e.q  = a / b;
            e.r  = a % b;
            e.dz = 1'b0;
        end
        return e;
    endfunction

    // Monitor: every done must match the oldest outstanding request.
    always @(negedge clk) begin : mon
        exp_t e;
        logic [63:0] recon;
        if (!reset) begin
            if (done) begin
                if (sb.size() == 0) begin
                    nvec++;
                    nfail++;
                    $display("FAIL spurious_done: got done at cycle %0d, expected none", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("quotient", 64'(q), 64'(e.q));
                    chk("remainder", 64'(r), 64'(e.r));
                    chk("div_zero", 64'(div_zero), 64'(e.dz));
                    chk("latency", 64'(cyc), 64'(e.acc + W));
                    chk("busy_cycles", 64'(busy_run), 64'(W));
                    if (e.b != 0) begin
                        recon = 64'(q) * 64'(e.b) + 64'(r);
                        chk("identity", recon, 64'(e.a));
                        chk("rem_lt_div", 64'(r < e.b), 64'd1);
                    end
                end
            end
            if (busy) busy_run++;
            else busy_run = 0;
        end else begin
            busy_run = 0;
        end
    end

    task automatic issue(logic [W-1:0] a, logic [W-1:0] b, bit push);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        if (push) sb.push_back(model(a, b, cyc + 1));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            nvec++;
            nfail++;
            $display("FAIL done_timeout: got no done in %0d cycles, expected one", n);
        end
    endtask

    task automatic op(logic [W-1:0] a, logic [W-1:0] b);
        issue(a, b, 1'b1);
        wait_done();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        repeat (3) @(negedge clk);
        chk("rst_q", 64'(q), 64'd0);
        chk("rst_r", 64'(r), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_dz", 64'(div_zero), 64'd0);
        reset = 1'b0;

        op(100, 7);
        op(32'hFFFF_FFFF, 1);
        op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        op(5, 9);
        op(32'h1234_5678, 0);

        // A start during RUN must be ignored.
        issue(100, 7, 1'b1);
        repeat (8) @(negedge clk);
        start    = 1'b1;
        dividend = 50;
        divisor  = 5;
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // Reset mid-RUN abandons the operation and clears outputs.
        issue(100, 7, 1'b0);
        repeat (14) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_q", 64'(q), 64'd0);
        chk("midrst_r", 64'(r), 64'd0);
        reset = 1'b0;
        op(81, 9);

        // Reset wins over a simultaneous start.
        @(negedge clk);
        reset    = 1'b1;
        start    = 1'b1;
        dividend = 77;
        divisor  = 3;
        @(negedge clk);
        chk("rst_start_busy", 64'(busy), 64'd0);
        chk("rst_start_q", 64'(q), 64'd0);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("rst_start_idle", 64'(busy), 64'd0);

        // Back-to-back: start held high, second op accepted in DONE.
        @(negedge clk);
        start    = 1'b1;
        dividend = 100;
        divisor  = 7;
        sb.push_back(model(100, 7, cyc + 1));
        wait_done();
        dividend = 1000;
        divisor  = 3;
        sb.push_back(model(1000, 3, cyc + 1));
        @(negedge clk);
        start = 1'b0;
        wait_done();

        for (int i = 0; i < 30; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = '0;
                1, 2:    rb = $urandom_range(1, 15);
                3, 4:    rb = ra >> $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            op(ra, rb);
        end

        repeat (3) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
